if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage RV64 pipeline. Owns the PC register and the IF/ID pipeline register.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and the fetch-state encoding for the RV64 pipeline front end.
package pipeline_pkg;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
   localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_0000;
   localparam logic [63:0] RESET_PC_DEF   = 64'h0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load enable, synchronous clear to NOP bubble, valid bit.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_clear,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_pc,
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_pc,
   output logic [31:0]     o_instr,
   output logic            o_valid
);
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_instr;
   logic            r_valid;

   // Clear beats load so a redirect or halt always leaves a bubble behind.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_pc    <= '0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_valid <= 1'b1;
      end
   end

   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_valid = r_valid;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, RUN/HALT control, stall/flush counters, IF/ID register.
module if_stage
   import pipeline_pkg::*;
#(
   parameter int              XLEN       = 64,
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF[XLEN-1:0],
   parameter logic [31:0]     HALT_INSTR = HALT_INSTR_DEF,
   parameter int              CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_write,
   input  logic             IF_ID_write,
   input  logic             flush,
   input  logic [XLEN-1:0]  branch_target,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [XLEN-1:0]  IF_ID_pc,
   output logic [31:0]      IF_ID_instr,
   output logic             IF_ID_valid,
   output logic [4:0]       IF_ID_rs1,
   output logic [4:0]       IF_ID_rs2,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   fetch_state_t     r_state, w_state_next;
   logic [XLEN-1:0]  r_pc, w_pc_next;
   logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_next;
   logic [CNT_W-1:0] r_flush_cnt, w_flush_cnt_next;
   logic             w_ifid_clear;
   logic             w_ifid_load;
   logic [XLEN-1:0]  w_target_aligned;

   assign w_target_aligned = branch_target & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_pc        <= RESET_PC;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_pc        <= w_pc_next;
         r_stall_cnt <= w_stall_cnt_next;
         r_flush_cnt <= w_flush_cnt_next;
      end
   end

   // Priority: flush > halt-detect > stall > normal; HALT holds everything.
   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_stall_cnt_next = r_stall_cnt;
      w_flush_cnt_next = r_flush_cnt;
      w_ifid_clear     = 1'b0;
      w_ifid_load      = 1'b0;
      if (flush) begin
         w_pc_next        = w_target_aligned;
         w_ifid_clear     = 1'b1;
         w_flush_cnt_next = r_flush_cnt + 1'b1;
         w_state_next     = ST_RUN;
      end else if (r_state == ST_RUN) begin
         if (pc_write && (imem_rdata == HALT_INSTR)) begin
            w_ifid_clear = 1'b1;
            w_state_next = ST_HALT;
         end else begin
            if (pc_write) begin
               w_pc_next = r_pc + XLEN'(4);
            end else begin
               w_stall_cnt_next = r_stall_cnt + 1'b1;
            end
            w_ifid_load = IF_ID_write;
         end
      end
   end

   if_id_reg #(
      .XLEN (XLEN)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_ifid_clear),
      .i_load  (w_ifid_load),
      .i_pc    (r_pc),
      .i_instr (imem_rdata),
      .o_pc    (IF_ID_pc),
      .o_instr (IF_ID_instr),
      .o_valid (IF_ID_valid)
   );

   assign imem_addr   = r_pc;
   assign IF_ID_rs1   = IF_ID_instr[19:15];
   assign IF_ID_rs2   = IF_ID_instr[24:20];
   assign halted      = (r_state == ST_HALT);
   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected post-edge state queued per step, popped and checked after the edge.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        reset, pc_write, IF_ID_write, flush;
   logic [63:0] branch_target, imem_addr, IF_ID_pc;
   logic [31:0] imem_rdata, IF_ID_instr, stall_count, flush_count;
   logic        IF_ID_valid, halted;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [63:0] pc;
      bit          chk_ifpc;
      logic [63:0] ifpc;
      logic [31:0] instr;
      logic        valid;
      logic        halted;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t sb_q[$];

   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] ADD  = 32'h00c5_8733;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   always #5 clk = ~clk;

   if_stage dut (
      .clk           (clk),
      .reset         (reset),
      .pc_write      (pc_write),
      .IF_ID_write   (IF_ID_write),
      .flush         (flush),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .IF_ID_pc      (IF_ID_pc),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_valid   (IF_ID_valid),
      .IF_ID_rs1     (IF_ID_rs1),
      .IF_ID_rs2     (IF_ID_rs2),
      .halted        (halted),
      .stall_count   (stall_count),
      .flush_count   (flush_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, queue its expected result, then pop and compare after the edge.
   task automatic cyc(input logic rst, input logic pw, input logic iw, input logic fl,
                      input logic [63:0] tgt, input logic [31:0] rdata, input exp_t e);
      exp_t   got;
      reset = rst; pc_write = pw; IF_ID_write = iw; flush = fl;
      branch_target = tgt; imem_rdata = rdata;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      chk({got.tag, ".imem_addr"},   imem_addr,   got.pc);
      if (got.chk_ifpc) chk({got.tag, ".IF_ID_pc"}, IF_ID_pc, got.ifpc);
      chk({got.tag, ".IF_ID_instr"}, 64'(IF_ID_instr), 64'(got.instr));
      chk({got.tag, ".IF_ID_valid"}, 64'(IF_ID_valid), 64'(got.valid));
      chk({got.tag, ".IF_ID_rs1"},   64'(IF_ID_rs1),   64'(got.instr[19:15]));
      chk({got.tag, ".IF_ID_rs2"},   64'(IF_ID_rs2),   64'(got.instr[24:20]));
      chk({got.tag, ".halted"},      64'(halted),      64'(got.halted));
      chk({got.tag, ".stall_count"}, 64'(stall_count), 64'(got.stall));
      chk({got.tag, ".flush_count"}, 64'(flush_count), 64'(got.flush));
      $display("step %-12s addr=%h ifid_pc=%h instr=%h v=%0d halt=%0d stall=%0d flush=%0d",
               got.tag, imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, halted,
               stall_count, flush_count);
   endtask

   function automatic exp_t mk(input string tag, input logic [63:0] pc, input bit cp,
                               input logic [63:0] ifpc, input logic [31:0] instr,
                               input logic v, input logic h, input logic [31:0] s,
                               input logic [31:0] f);
      exp_t e;
      e.tag = tag; e.pc = pc; e.chk_ifpc = cp; e.ifpc = ifpc; e.instr = instr;
      e.valid = v; e.halted = h; e.stall = s; e.flush = f;
      return e;
   endfunction

   initial begin
      reset = 1'b1; pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
      branch_target = '0; imem_rdata = ADDI;

      // reset state
      cyc(1, 1, 1, 0, 0, ADDI, mk("reset", 64'h0, 1, 64'h0, NOP, 0, 0, 0, 0));
      chk("fetch0.imem_addr", imem_addr, 64'h0);
      // free run
      cyc(0, 1, 1, 0, 0, ADDI, mk("run1", 64'h4, 1, 64'h0, ADDI, 1, 0, 0, 0));
      cyc(0, 1, 1, 0, 0, ADDI, mk("run2", 64'h8, 1, 64'h4, ADDI, 1, 0, 0, 0));
      // stall both for 2 cycles at pc=8
      cyc(0, 0, 0, 0, 0, ADDI, mk("stall1", 64'h8, 1, 64'h4, ADDI, 1, 0, 1, 0));
      cyc(0, 0, 0, 0, 0, ADDI, mk("stall2", 64'h8, 1, 64'h4, ADDI, 1, 0, 2, 0));
      // flush overrides stall, misaligned target
      cyc(0, 0, 0, 1, 64'h103, ADDI, mk("flush103", 64'h100, 0, 64'h0, NOP, 0, 0, 2, 1));
      cyc(0, 1, 1, 0, 0, ADDI, mk("run100", 64'h104, 1, 64'h100, ADDI, 1, 0, 2, 1));
      cyc(0, 1, 1, 1, 64'h20, ADDI, mk("flush20", 64'h20, 0, 64'h0, NOP, 0, 0, 2, 2));
      // halt detect at 0x20
      cyc(0, 1, 1, 0, 0, 32'h0, mk("halt", 64'h20, 0, 64'h0, NOP, 0, 1, 2, 2));
      for (int i = 0; i < 5; i++)
         cyc(0, 1, 1, 0, 0, ADDI, mk("halt_hold", 64'h20, 0, 64'h0, NOP, 0, 1, 2, 2));
      cyc(0, 0, 1, 0, 0, ADDI, mk("halt_nostall", 64'h20, 0, 64'h0, NOP, 0, 1, 2, 2));
      // leave HALT via flush
      cyc(0, 1, 1, 1, 64'h40, ADDI, mk("unhalt", 64'h40, 0, 64'h0, NOP, 0, 0, 2, 3));
      cyc(0, 1, 1, 0, 0, ADDI, mk("run40", 64'h44, 1, 64'h40, ADDI, 1, 0, 2, 3));
      // independent enables
      cyc(0, 1, 0, 0, 0, ADD, mk("pc_only", 64'h48, 1, 64'h40, ADDI, 1, 0, 2, 3));
      cyc(0, 0, 1, 0, 0, ADD, mk("ifid_only", 64'h48, 1, 64'h48, ADD, 1, 0, 3, 3));
      // pc wrap
      cyc(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, ADDI,
          mk("flush_top", 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, NOP, 0, 0, 3, 4));
      cyc(0, 1, 1, 0, 0, ADDI,
          mk("wrap", 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, ADDI, 1, 0, 3, 4));
      // reset mid-stall
      cyc(0, 0, 0, 0, 0, ADD, mk("stall_pre", 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, ADDI, 1, 0, 4, 4));
      cyc(1, 0, 0, 0, 0, ADD, mk("reset_mid", 64'h0, 1, 64'h0, NOP, 0, 0, 0, 0));
      cyc(0, 1, 1, 0, 0, ADD, mk("post_reset", 64'h4, 1, 64'h0, ADD, 1, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
